hazard_ctrl: RTL and testbench

Pipeline control unit for the five-stage MIPS datapath: it drives the enable and flush controls of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and the PC enable. It resolves memory waits, load-use hazards, taken branches, jumps, instruction-fetch misses and halt. It tracks memory-wait and halt state in a small FSM and keeps stall and flush performance counters. It sits beside the pipeline registers, taking hazard inputs from ID, EX and MEM and the cache hit signals.

---
 rtl/hazard_ctrl.sv | 153 +++++++++++++++
 tb/tb_hazard_ctrl.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline control for the 5-stage MIPS datapath: enables/flushes for each pipeline register plus PC enable.
// Controls are combinational from the current state and inputs; halt, the state and the counters are registered.
module hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             mem_dREN,
  input  logic             mem_dWEN,
  input  logic             mem_halt,
  input  logic             branch_taken,
  input  logic             jump_id,
  input  logic             ex_dREN,
  input  logic [4:0]       ex_rt,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  output logic             pc_en,
  output logic             IF_EN,
  output logic             ID_EN,
  output logic             EX_EN,
  output logic             MEM_EN,
  output logic             IF_FLUSH,
  output logic             ID_FLUSH,
  output logic             EX_FLUSH,
  output logic             MEM_FLUSH,
  output logic             halt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MEMWAIT = 2'd1,
    HALTED  = 2'd2
  } state_t;

  state_t state, next_state;

  logic mem_busy;
  logic load_use;
  logic redirect;

  assign mem_busy = (mem_dREN | mem_dWEN) & ~dhit;
  assign load_use = ex_dREN & (ex_rt != 5'd0) & ((ex_rt == id_rs) | (ex_rt == id_rt));
  // A branch only redirects once any memory wait ahead of it has resolved.
  assign redirect = (state != HALTED) & ~mem_busy & ~mem_halt & branch_taken;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= RUN;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      RUN, MEMWAIT: begin
        if (mem_busy) begin
          next_state = MEMWAIT;
        end else if (mem_halt) begin
          next_state = HALTED;
        end else begin
          next_state = RUN;
        end
      end
      HALTED:  next_state = HALTED;
      default: next_state = RUN;
    endcase
  end

  always_comb begin
    pc_en     = 1'b0;
    IF_EN     = 1'b0;
    ID_EN     = 1'b0;
    EX_EN     = 1'b0;
    MEM_EN    = 1'b0;
    IF_FLUSH  = 1'b0;
    ID_FLUSH  = 1'b0;
    EX_FLUSH  = 1'b0;
    MEM_FLUSH = 1'b0;
    if (!nRST) begin
      IF_FLUSH  = 1'b1;
      ID_FLUSH  = 1'b1;
      EX_FLUSH  = 1'b1;
      MEM_FLUSH = 1'b1;
    end else if (state != HALTED) begin
      if (mem_busy) begin
        MEM_FLUSH = 1'b1;
      end else if (mem_halt) begin
        // Let the halt retire into MEM/WB while squashing everything younger.
        IF_EN    = 1'b1;
        ID_EN    = 1'b1;
        EX_EN    = 1'b1;
        MEM_EN   = 1'b1;
        IF_FLUSH = 1'b1;
        ID_FLUSH = 1'b1;
        EX_FLUSH = 1'b1;
      end else if (branch_taken) begin
        pc_en    = 1'b1;
        IF_EN    = 1'b1;
        ID_EN    = 1'b1;
        EX_EN    = 1'b1;
        MEM_EN   = 1'b1;
        IF_FLUSH = 1'b1;
        ID_FLUSH = 1'b1;
        EX_FLUSH = 1'b1;
      end else if (load_use) begin
        ID_FLUSH = 1'b1;
        EX_EN    = 1'b1;
        MEM_EN   = 1'b1;
      end else if (jump_id) begin
        pc_en    = 1'b1;
        IF_EN    = 1'b1;
        ID_EN    = 1'b1;
        EX_EN    = 1'b1;
        MEM_EN   = 1'b1;
        IF_FLUSH = 1'b1;
      end else if (!ihit) begin
        IF_FLUSH = 1'b1;
        ID_EN    = 1'b1;
        EX_EN    = 1'b1;
        MEM_EN   = 1'b1;
      end else begin
        pc_en  = 1'b1;
        IF_EN  = 1'b1;
        ID_EN  = 1'b1;
        EX_EN  = 1'b1;
        MEM_EN = 1'b1;
      end
    end
  end

  assign halt = (state == HALTED);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if ((state != HALTED) && !pc_en && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      if (redirect && (flush_cnt != '1)) begin
        flush_cnt <= flush_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios then random traffic against a rule-table reference model.
module tb_hazard_ctrl;

  localparam int CNT_W = 4;
  localparam int SAT   = (1 << CNT_W) - 1;

  logic             CLK = 1'b0;
  logic             nRST;
  logic             ihit, dhit, mem_dREN, mem_dWEN, mem_halt, branch_taken, jump_id, ex_dREN;
  logic [4:0]       ex_rt, id_rs, id_rt;
  logic             pc_en, IF_EN, ID_EN, EX_EN, MEM_EN;
  logic             IF_FLUSH, ID_FLUSH, EX_FLUSH, MEM_FLUSH, halt;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  hazard_ctrl #(.CNT_W(CNT_W)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
    .mem_dREN(mem_dREN), .mem_dWEN(mem_dWEN), .mem_halt(mem_halt),
    .branch_taken(branch_taken), .jump_id(jump_id), .ex_dREN(ex_dREN),
    .ex_rt(ex_rt), .id_rs(id_rs), .id_rt(id_rt),
    .pc_en(pc_en), .IF_EN(IF_EN), .ID_EN(ID_EN), .EX_EN(EX_EN), .MEM_EN(MEM_EN),
    .IF_FLUSH(IF_FLUSH), .ID_FLUSH(ID_FLUSH), .EX_FLUSH(EX_FLUSH), .MEM_FLUSH(MEM_FLUSH),
    .halt(halt), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: only "halted or not" matters to the outputs.
  bit m_halted;
  int m_stall, m_flush;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Control vector order: {pc_en, IF_EN, ID_EN, EX_EN, MEM_EN, IF_FLUSH, ID_FLUSH, EX_FLUSH, MEM_FLUSH}
  function automatic logic [8:0] model_ctl();
    bit busy, lu;
    busy = (mem_dREN || mem_dWEN) && !dhit;
    lu   = ex_dREN && ex_rt != 0 && (ex_rt == id_rs || ex_rt == id_rt);
    if (!nRST)            return 9'b0_0000_1111;
    if (m_halted)         return 9'b0_0000_0000;
    if (busy)             return 9'b0_0000_0001;
    if (mem_halt)         return 9'b0_1111_1110;
    if (branch_taken)     return 9'b1_1111_1110;
    if (lu)               return 9'b0_0011_0100;
    if (jump_id)          return 9'b1_1111_1000;
    if (!ihit)            return 9'b0_0111_1000;
    return 9'b1_1111_0000;
  endfunction

  function automatic logic [8:0] dut_ctl();
    return {pc_en, IF_EN, ID_EN, EX_EN, MEM_EN, IF_FLUSH, ID_FLUSH, EX_FLUSH, MEM_FLUSH};
  endfunction

  task automatic drive(input bit i, input bit d, input bit mr, input bit mw, input bit mh,
                       input bit br, input bit j, input bit exd,
                       input logic [4:0] ert, input logic [4:0] rs, input logic [4:0] rt);
    ihit = i; dhit = d; mem_dREN = mr; mem_dWEN = mw; mem_halt = mh;
    branch_taken = br; jump_id = j; ex_dREN = exd; ex_rt = ert; id_rs = rs; id_rt = rt;
  endtask

  task automatic idle();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
  endtask

  // Inputs are applied at the falling edge; check mid-cycle, then advance the model on the rising edge.
  task automatic step(input string tag);
    logic [8:0] exp;
    bit busy;
    #1;
    exp  = model_ctl();
    busy = (mem_dREN || mem_dWEN) && !dhit;
    check({tag, ".ctl"}, 32'(dut_ctl()), 32'(exp));
    check({tag, ".halt"}, 32'(halt), 32'(m_halted));
    check({tag, ".stall"}, 32'(stall_cnt), 32'(m_stall));
    check({tag, ".flush"}, 32'(flush_cnt), 32'(m_flush));
    @(posedge CLK);
    if (!m_halted) begin
      if (!exp[8] && m_stall < SAT) m_stall++;
      if (!busy && !mem_halt && branch_taken && m_flush < SAT) m_flush++;
      if (!busy && mem_halt) m_halted = 1;
    end
    @(negedge CLK);
  endtask

  // Reset asserted mid-cycle to exercise the asynchronous path.
  task automatic pulse_reset(input string tag);
    #2 nRST = 1'b0;
    #1;
    m_halted = 0; m_stall = 0; m_flush = 0;
    check({tag, ".rst_ctl"}, 32'(dut_ctl()), 32'(model_ctl()));
    check({tag, ".rst_halt"}, 32'(halt), 32'(m_halted));
    check({tag, ".rst_stall"}, 32'(stall_cnt), 32'(m_stall));
    check({tag, ".rst_flush"}, 32'(flush_cnt), 32'(m_flush));
    @(negedge CLK);
    nRST = 1'b1;
  endtask

  initial begin
    nRST = 1'b0;
    idle();
    m_halted = 0; m_stall = 0; m_flush = 0;
    @(negedge CLK);
    pulse_reset("reset");

    idle();
    step("normal");

    // Store waiting three cycles on the data cache.
    for (int k = 0; k < 3; k++) begin
      drive(1, 0, 0, 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
      step("memwait");
    end
    drive(1, 1, 0, 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
    step("memdone");
    idle();
    step("after_mem");
    check("stall_after_mem", 32'(stall_cnt), 32'd3);

    // Load-use on rt, then the load has moved on.
    drive(1, 0, 0, 0, 0, 0, 0, 1, 5'd5, 5'd1, 5'd5);
    step("load_use");
    drive(1, 0, 0, 0, 0, 0, 0, 0, 5'd5, 5'd1, 5'd5);
    step("load_use_next");
    drive(1, 0, 0, 0, 0, 0, 0, 1, 5'd0, 5'd0, 5'd0);
    step("load_r0");
    drive(0, 0, 0, 0, 0, 0, 0, 1, 5'd7, 5'd7, 5'd2);
    step("load_use_imiss");

    // Branch beats jump and load-use.
    pulse_reset("pre_branch");
    drive(1, 0, 0, 0, 0, 1, 1, 1, 5'd3, 5'd3, 5'd0);
    step("branch_all");
    check("flush_one", 32'(flush_cnt), 32'd1);
    drive(1, 0, 1, 0, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0);
    step("busy_branch");
    drive(1, 1, 1, 0, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0);
    step("dhit_branch");
    drive(0, 0, 0, 0, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0);
    step("jump_imiss");

    // Halt, then ten frozen cycles under random inputs, then reset out of it.
    drive(1, 1, 1, 0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0);
    step("halt_entry");
    for (int k = 0; k < 10; k++) begin
      drive($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
            $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
            $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
      step("halted");
    end
    pulse_reset("halt_reset");
    idle();
    step("after_halt");

    // Saturation of the stall counter.
    drive(0, 0, 0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
    for (int k = 0; k < 20; k++) step("imiss_sat");
    check("stall_sat", 32'(stall_cnt), 32'(SAT));

    // Random traffic.
    for (int k = 0; k < 800; k++) begin
      if ($urandom_range(0, 99) < 2) pulse_reset("rand_rst");
      drive($urandom_range(0, 99) < 75, $urandom_range(0, 99) < 50,
            $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 15,
            $urandom_range(0, 99) < 2, $urandom_range(0, 99) < 12,
            $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 30,
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
      step("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
